// File: rtl/polyphase_tap_loader.sv
// -----------------------------------------------------------------------------
// polyphase_tap_loader
//
// Collects one binary sample per polyphase sub-filter into a staging buffer,
// then shifts the whole staged set into the per-phase tap delay lines in a
// single load. Each load fires a one-cycle start pulse to the downstream
// stochastic (HWA/VDC) evaluators and opens an evaluation window of SC_LEN
// cycles. The taps are held frozen for the whole window. Staging keeps
// filling during a window. A full staging buffer waits for the window to end.
//
// Parameters
//   N       sample magnitude bits; samples are N+1 bits wide
//   ORDER   filter order; each phase holds ORDER+1 taps
//   PHASES  number of polyphase sub-filters
//   SC_LEN  stochastic evaluation window length in cycles
//
// Ports
//   clock      single clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_data    binary input sample (N+1 bits)
//   in_valid   in_data is valid
//   in_ready   a sample can be accepted this cycle (staging not full)
//   clear      synchronous flush of taps, staging and window state
//   taps       flattened taps; phase p, tap k at ((p*(ORDER+1))+k)*(N+1)
//   start      one-cycle pulse per load
//   busy       evaluation window in progress, taps frozen
//   frame_cnt  number of completed loads, wraps at 2^16
// -----------------------------------------------------------------------------
module polyphase_tap_loader #(
   parameter int N      = 12,
   parameter int ORDER  = 18,
   parameter int PHASES = 4,
   parameter int SC_LEN = 4096
) (
   input  logic                                  clock,
   input  logic                                  reset_n,
   input  logic [N:0]                            in_data,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic                                  clear,
   output logic [PHASES*(ORDER+1)*(N+1)-1:0]     taps,
   output logic                                  start,
   output logic                                  busy,
   output logic [15:0]                           frame_cnt
);

   localparam int W  = N + 1;
   localparam int NT = ORDER + 1;
   localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
   localparam int CW = (SC_LEN > 1) ? $clog2(SC_LEN) : 1;

   localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);
   localparam logic [CW-1:0] WIN_LOAD   = CW'(SC_LEN - 1);

   // Staging slots, one per phase, plus the staging-full flag.
   logic [W-1:0]  stage_p0 [PHASES];
   logic          vld_p0;
   logic [PW-1:0] phase;

   // Tap delay lines, one per phase.
   logic [W-1:0]  tap_p1 [PHASES][NT];

   // Window control.
   logic [CW-1:0] win_cnt;
   logic          busy_r;
   logic          start_r;
   logic [15:0]   frame_r;

   logic          accept;
   logic          load;

   // Ready depends only on staging occupancy, never on the window, so the
   // producer can keep refilling staging while the taps are frozen.
   assign in_ready = ~vld_p0;
   assign accept   = in_valid & ~vld_p0;
   // A full staging set moves into the taps as soon as no window is open.
   // accept and load are mutually exclusive because accept needs ~vld_p0.
   assign load     = vld_p0 & ~busy_r;

   // ---- stage 0: sample staging -------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < PHASES; p++) begin
            stage_p0[p] <= '0;
         end
         vld_p0 <= 1'b0;
         phase  <= '0;
      end else if (clear) begin
         // clear wins over a simultaneous accept; the offered sample is lost
         for (int p = 0; p < PHASES; p++) begin
            stage_p0[p] <= '0;
         end
         vld_p0 <= 1'b0;
         phase  <= '0;
      end else if (load) begin
         for (int p = 0; p < PHASES; p++) begin
            stage_p0[p] <= '0;
         end
         vld_p0 <= 1'b0;
      end else if (accept) begin
         stage_p0[phase] <= in_data;
         if (phase == LAST_PHASE) begin
            phase  <= '0;
            vld_p0 <= 1'b1;
         end else begin
            phase <= phase + 1'b1;
         end
      end
   end

   // ---- stage 1: tap delay lines ------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < PHASES; p++) begin
            for (int k = 0; k < NT; k++) begin
               tap_p1[p][k] <= '0;
            end
         end
      end else if (clear) begin
         for (int p = 0; p < PHASES; p++) begin
            for (int k = 0; k < NT; k++) begin
               tap_p1[p][k] <= '0;
            end
         end
      end else if (load) begin
         for (int p = 0; p < PHASES; p++) begin
            for (int k = NT - 1; k > 0; k--) begin
               tap_p1[p][k] <= tap_p1[p][k-1];
            end
            tap_p1[p][0] <= stage_p0[p];
         end
      end
   end

   // ---- window control ----------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         start_r <= 1'b0;
         busy_r  <= 1'b0;
         win_cnt <= '0;
         frame_r <= '0;
      end else if (clear) begin
         // frame_cnt survives a flush; only reset zeroes it
         start_r <= 1'b0;
         busy_r  <= 1'b0;
         win_cnt <= '0;
      end else begin
         start_r <= load;
         if (load) begin
            busy_r  <= 1'b1;
            win_cnt <= WIN_LOAD;
            frame_r <= frame_r + 16'd1;
         end else if (busy_r) begin
            // counter runs SC_LEN-1 .. 0, so busy spans exactly SC_LEN cycles
            if (win_cnt == '0) begin
               busy_r <= 1'b0;
            end else begin
               win_cnt <= win_cnt - 1'b1;
            end
         end
      end
   end

   assign start     = start_r;
   assign busy      = busy_r;
   assign frame_cnt = frame_r;

   // Flatten taps: phase-major, tap index minor.
   for (genvar gp = 0; gp < PHASES; gp++) begin : g_phase
      for (genvar gk = 0; gk < NT; gk++) begin : g_tap
         assign taps[((gp*NT)+gk)*W +: W] = tap_p1[gp][gk];
      end
   end

endmodule

// File: tb/tb_polyphase_tap_loader.sv
module tb_polyphase_tap_loader;

   localparam int N      = 12;
   localparam int ORDER  = 18;
   localparam int PHASES = 4;
   localparam int SCS    = 16;
   localparam int NT     = ORDER + 1;
   localparam int W      = N + 1;
   localparam int PWW    = NT * W;
   localparam int TW     = PHASES * PWW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [N:0]    in_data;
   logic          in_valid;
   logic          clear;

   logic          ready_s, start_s, busy_s;
   logic [TW-1:0] taps_s;
   logic [15:0]   frame_s;

   logic          ready_b, start_b, busy_b;
   logic [TW-1:0] taps_b;
   logic [15:0]   frame_b;

   // Short-window instance carries the bulk of the scenarios.
   polyphase_tap_loader #(.N(N), .ORDER(ORDER), .PHASES(PHASES), .SC_LEN(SCS)) dut_s (
      .clock(clk), .reset_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ready_s), .clear(clear), .taps(taps_s), .start(start_s),
      .busy(busy_s), .frame_cnt(frame_s));

   // Default-parameter instance, same stimulus, used for the first window.
   polyphase_tap_loader dut_b (
      .clock(clk), .reset_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ready_b), .clear(clear), .taps(taps_b), .start(start_b),
      .busy(busy_b), .frame_cnt(frame_b));

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [TW-1:0] taps;
      logic [15:0]   frame;
   } exp_t;
   exp_t expq[$];

   logic [N:0]  m_tap [PHASES][NT];
   logic [N:0]  m_stage [PHASES];
   int          m_phase;
   logic [15:0] m_frame;

   // First default-instance window: length and start pulses.
   int big_len = 0;
   int big_starts = 0;
   bit big_done = 1'b0;
   always @(negedge clk) begin
      if (!big_done) begin
         if (start_b) big_starts++;
         if (busy_b) big_len++;
         else if (big_len != 0) big_done = 1'b1;
      end
   end

   int acc_cnt = 0;
   always @(negedge clk) begin
      if (rst_n && in_valid && ready_s && !clear) acc_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   function automatic logic [N:0] tap_s(input int p, input int k);
      return taps_s[((p*NT)+k)*W +: W];
   endfunction

   function automatic logic [N:0] tap_b(input int p, input int k);
      return taps_b[((p*NT)+k)*W +: W];
   endfunction

   function automatic logic [TW-1:0] pack_model();
      logic [TW-1:0] v;
      v = '0;
      for (int p = 0; p < PHASES; p++)
         for (int k = 0; k < NT; k++)
            v[((p*NT)+k)*W +: W] = m_tap[p][k];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic chkw(input string nm, input logic [PWW-1:0] act, input logic [PWW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic model_reset(input bit keep_frame);
      for (int p = 0; p < PHASES; p++) begin
         m_stage[p] = '0;
         for (int k = 0; k < NT; k++) m_tap[p][k] = '0;
      end
      m_phase = 0;
      if (!keep_frame) m_frame = '0;
   endtask

   task automatic model_accept(input logic [N:0] v);
      exp_t e;
      m_stage[m_phase] = v;
      if (m_phase == PHASES - 1) begin
         m_phase = 0;
         for (int p = 0; p < PHASES; p++) begin
            for (int k = NT - 1; k > 0; k--) m_tap[p][k] = m_tap[p][k-1];
            m_tap[p][0] = m_stage[p];
         end
         m_frame = m_frame + 16'd1;
         e.taps  = pack_model();
         e.frame = m_frame;
         expq.push_back(e);
      end else begin
         m_phase++;
      end
   endtask

   task automatic send(input logic [N:0] v);
      int n;
      n = 0;
      in_data  = v;
      in_valid = 1'b1;
      while (!ready_s && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ready_s) begin
         checks++;
         failures++;
         $display("FAIL send_wait actual=ready_low required=ready_within_200");
      end else begin
         model_accept(v);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int lim);
      int n;
      n = 0;
      while (expq.size() != 0 && n < lim) begin
         @(posedge clk); #1;
         n++;
      end
      if (expq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_wait actual=%0d required=0", expq.size());
      end
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      while (busy_s && n < lim) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_wait", 32'(busy_s), 0);
   endtask

   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && start_s) begin
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_start actual=start required=no_start");
            end else begin
               e = expq.pop_front();
               chk("sb_frame", 32'(frame_s), 32'(e.frame));
               for (int p = 0; p < PHASES; p++)
                  chkw($sformatf("sb_taps_p%0d", p), taps_s[p*PWW +: PWW], e.taps[p*PWW +: PWW]);
            end
         end
      end
   endtask

   initial begin
      int n;
      int acc0;
      fork
         monitor_loop();
      join_none

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;
      model_reset(0);
      repeat (3) @(posedge clk);
      #1;
      for (int p = 0; p < PHASES; p++)
         chkw($sformatf("rst_taps_p%0d", p), taps_s[p*PWW +: PWW], '0);
      chk("rst_start", 32'(start_s), 0);
      chk("rst_busy", 32'(busy_s), 0);
      chk("rst_frame", 32'(frame_s), 0);
      chk("rst_busy_b", 32'(busy_b), 0);
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", 32'(ready_s), 1);
      @(posedge clk); #1;

      // first load: 1,2,3,4
      for (int i = 1; i <= 4; i++) send(W'(i));
      @(posedge clk); #1;
      for (int p = 0; p < PHASES; p++)
         chk($sformatf("t1_tap_b_p%0d_0", p), 32'(tap_b(p, 0)), p + 1);
      chk("t1_start_b", 32'(start_b), 1);
      chk("t1_frame_b", 32'(frame_b), 1);
      chk("t1_busy_s", 32'(busy_s), 1);

      // refill during the window: 5,6,7,8
      for (int i = 5; i <= 8; i++) send(W'(i));
      chk("t2_ready_full", 32'(ready_s), 0);
      chk("t2_tap_frozen", 32'(tap_s(0, 0)), 1);
      chk("t2_busy", 32'(busy_s), 1);
      wait_idle(100);
      chk("t2_idle_start", 32'(start_s), 0);
      chk("t2_idle_tap", 32'(tap_s(0, 0)), 1);
      @(posedge clk); #1;
      chk("t2_load_start", 32'(start_s), 1);
      chk("t2_tap00", 32'(tap_s(0, 0)), 5);
      chk("t2_tap01", 32'(tap_s(0, 1)), 1);
      chk("t2_frame", 32'(frame_s), 2);

      // default-length window measured on the default instance
      n = 0;
      while (!big_done && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!big_done) begin
         checks++;
         failures++;
         $display("FAIL big_window_wait actual=busy required=window_end");
      end else begin
         chk("big_busy_len", big_len, 4096);
         chk("big_start_pulses", big_starts, 1);
      end

      // reset in the middle of a window
      for (int i = 9; i <= 12; i++) send(W'(i));
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("t3_busy_before", 32'(busy_s), 1);
      rst_n = 1'b0;
      #1;
      for (int p = 0; p < PHASES; p++)
         chkw($sformatf("t3_taps_p%0d", p), taps_s[p*PWW +: PWW], '0);
      chk("t3_busy", 32'(busy_s), 0);
      chk("t3_start", 32'(start_s), 0);
      chk("t3_frame", 32'(frame_s), 0);
      chk("t3_frame_b", 32'(frame_b), 0);
      model_reset(0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("t3_busy_after", 32'(busy_s), 0);
      chk("t3_frame_after", 32'(frame_s), 0);

      // twenty loads, phase-0 value = load index
      for (int i = 1; i <= 20; i++) begin
         send(W'(i));
         send(W'(i + 32));
         send(W'(i + 64));
         send(W'(i + 96));
      end
      wait_drain(500);
      for (int k = 0; k < NT; k++)
         chk($sformatf("t4_tap0_%0d", k), 32'(tap_s(0, k)), 20 - k);
      chk("t4_tap3_0", 32'(tap_s(3, 0)), 116);
      chk("t4_frame", 32'(frame_s), 20);

      // clear during a window with two staged samples
      send(W'(12'h0AA));
      send(W'(12'h0BB));
      chk("t5_busy_before", 32'(busy_s), 1);
      clear = 1'b1; in_data = W'(12'h155); in_valid = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0;
      chk("t5_busy", 32'(busy_s), 0);
      chk("t5_start", 32'(start_s), 0);
      chk("t5_ready", 32'(ready_s), 1);
      chk("t5_frame_kept", 32'(frame_s), 20);
      for (int p = 0; p < PHASES; p++)
         chkw($sformatf("t5_taps_p%0d", p), taps_s[p*PWW +: PWW], '0);
      model_reset(1);
      for (int p = 0; p < PHASES; p++) send(W'(17 * (p + 1)));
      wait_drain(100);
      for (int p = 0; p < PHASES; p++)
         chk($sformatf("t5_tap_p%0d_0", p), 32'(tap_s(p, 0)), 17 * (p + 1));
      chk("t5_tap01", 32'(tap_s(0, 1)), 0);

      // in_valid held high with full-scale data
      wait_idle(100);
      for (int i = 0; i < 8; i++) model_accept(W'(13'h1FFF));
      acc0 = acc_cnt;
      in_data = W'(13'h1FFF); in_valid = 1'b1;
      repeat (19) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("t6_accepts", acc_cnt - acc0, 8);
      chk("t6_ready_full", 32'(ready_s), 0);
      wait_drain(200);
      chk("t6_tap00", 32'(tap_s(0, 0)), 32'h1FFF);
      chk("t6_tap31", 32'(tap_s(3, 1)), 32'h1FFF);
      chk("t6_tap02", 32'(tap_s(0, 2)), 32'h11);
      chk("t6_ready_after", 32'(ready_s), 1);
      chk("sb_drained", expq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
